// File: rtl/segm_if.sv
// Display bus for the hex seven-segment driver: raw value bits in, segment/point/enable drives out.
`timescale 1ns/1ps
interface segm_if;
    logic a, b, c, d;
    logic A, B, C, D, E, F, G;
    logic Dp;
    logic digit;

    modport master (output a, b, c, d, input A, B, C, D, E, F, G, Dp, digit);
    modport slave  (input a, b, c, d, output A, B, C, D, E, F, G, Dp, digit);
endinterface

// File: rtl/segm.sv
// Hex seven-segment driver: synchronizes the 4 raw value bits, decodes them and registers
// every display output so nothing combinational reaches the pins.
`timescale 1ns/1ps
module segm (
    input  logic   clk,
    input  logic   rst,
    segm_if.slave  bus
);
    logic [3:0] sync1_q, sync2_q;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       digit_q;

    // Segment order in the vector is A (bit 6) down to G (bit 0); every code is a real glyph.
    always_comb begin
        case (sync2_q)
            4'h0: seg_d = 7'b1111110;
            4'h1: seg_d = 7'b0110000;
            4'h2: seg_d = 7'b1101101;
            4'h3: seg_d = 7'b1111001;
            4'h4: seg_d = 7'b0110011;
            4'h5: seg_d = 7'b1011011;
            4'h6: seg_d = 7'b1011111;
            4'h7: seg_d = 7'b1110000;
            4'h8: seg_d = 7'b1111111;
            4'h9: seg_d = 7'b1111011;
            4'hA: seg_d = 7'b1110111;
            4'hB: seg_d = 7'b0011111;
            4'hC: seg_d = 7'b1001110;
            4'hD: seg_d = 7'b0111101;
            4'hE: seg_d = 7'b1001111;
            4'hF: seg_d = 7'b1000111;
        endcase
        dp_d = (sync2_q > 4'd9);
    end

    // Reset blanks the display and flushes the synchronizer so stale values never reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            seg_q   <= 7'd0;
            dp_q    <= 1'b0;
            digit_q <= 1'b0;
        end else begin
            sync1_q <= {bus.a, bus.b, bus.c, bus.d};
            sync2_q <= sync1_q;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            digit_q <= 1'b1;
        end
    end

    assign bus.A     = seg_q[6];
    assign bus.B     = seg_q[5];
    assign bus.C     = seg_q[4];
    assign bus.D     = seg_q[3];
    assign bus.E     = seg_q[2];
    assign bus.F     = seg_q[1];
    assign bus.G     = seg_q[0];
    assign bus.Dp    = dp_q;
    assign bus.digit = digit_q;
endmodule

// File: tb/tb_segm.sv
// Directed bench for segm: reset blanking, full hex sweep, latency edge, async toggling, mid-run reset.
`timescale 1ns/100ps
module tb_segm;
    typedef struct {
        logic [3:0] v;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    segm_if bus ();

    vec_t       vecs [16];
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [3:0] h0 = 4'd0, h1 = 4'd0, h2 = 4'd0;

    segm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Value seen by the DUT at each of the last three rising edges; h2 is what the outputs show now.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
        end else begin
            h2 = h1; h1 = h0; h0 = {bus.a, bus.b, bus.c, bus.d};
        end
    end

    task automatic applyStimulus(input logic [3:0] v);
        {bus.a, bus.b, bus.c, bus.d} = v;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] expSeg,
                               input logic expDp, input logic expDigit);
        logic [6:0] gotSeg;
        gotSeg = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};
        testsRun++;
        if (gotSeg !== expSeg || bus.Dp !== expDp || bus.digit !== expDigit) begin
            testsFailed++;
            $display("[TB] FAIL %s: got seg=%b dp=%b digit=%b, expected seg=%b dp=%b digit=%b",
                     name, gotSeg, bus.Dp, bus.digit, expSeg, expDp, expDigit);
        end
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'b1111110, 1'b0};
        vecs[1]  = '{4'h1, 7'b0110000, 1'b0};
        vecs[2]  = '{4'h2, 7'b1101101, 1'b0};
        vecs[3]  = '{4'h3, 7'b1111001, 1'b0};
        vecs[4]  = '{4'h4, 7'b0110011, 1'b0};
        vecs[5]  = '{4'h5, 7'b1011011, 1'b0};
        vecs[6]  = '{4'h6, 7'b1011111, 1'b0};
        vecs[7]  = '{4'h7, 7'b1110000, 1'b0};
        vecs[8]  = '{4'h8, 7'b1111111, 1'b0};
        vecs[9]  = '{4'h9, 7'b1111011, 1'b0};
        vecs[10] = '{4'hA, 7'b1110111, 1'b1};
        vecs[11] = '{4'hB, 7'b0011111, 1'b1};
        vecs[12] = '{4'hC, 7'b1001110, 1'b1};
        vecs[13] = '{4'hD, 7'b0111101, 1'b1};
        vecs[14] = '{4'hE, 7'b1001111, 1'b1};
        vecs[15] = '{4'hF, 7'b1000111, 1'b1};

        applyStimulus(4'h0);
        #1 rst = 1'b1;
        #1 checkOutput("resetBeforeClk", 7'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("resetHeld", 7'b0, 1'b0, 1'b0);

        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("firstEdgeAfterRelease", 7'b1111110, 1'b0, 1'b1);

        // Sweep every value, with an asynchronous reset dropped in partway through.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk) applyStimulus(vecs[i].v);
            repeat (5) @(posedge clk);
            #1 checkOutput($sformatf("sweep%0h", i), vecs[i].seg, vecs[i].dp, 1'b1);
            if (i == 10) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1 checkOutput("midResetBlank", 7'b0, 1'b0, 1'b0);
                @(negedge clk) rst = 1'b0;
                @(posedge clk); #1;
                checkOutput("midResetFlushed", 7'b1111110, 1'b0, 1'b1);
                repeat (2) @(posedge clk);
                #1 checkOutput("midResetRefill", vecs[i].seg, vecs[i].dp, 1'b1);
            end
        end

        // 7 -> 8 must appear on exactly the third edge after the change.
        @(negedge clk) applyStimulus(4'h7);
        repeat (5) @(posedge clk);
        @(negedge clk) applyStimulus(4'h8);
        @(posedge clk); #1 checkOutput("step78edge1", 7'b1110000, 1'b0, 1'b1);
        @(posedge clk); #1 checkOutput("step78edge2", 7'b1110000, 1'b0, 1'b1);
        @(posedge clk); #1 checkOutput("step78edge3", 7'b1111111, 1'b0, 1'b1);

        // Free-running toggles; the 0.3 ns offset keeps input changes off the clock edges.
        @(negedge clk);
        #0.3;
        fork
            for (int k = 0; k < 35; k++) begin #17 bus.a = ~bus.a; end
            for (int k = 0; k < 20; k++) begin #29 bus.b = ~bus.b; end
            for (int k = 0; k < 15; k++) begin #39 bus.c = ~bus.c; end
            for (int k = 0; k < 9;  k++) begin #61 bus.d = ~bus.d; end
            for (int k = 0; k < 60; k++) begin
                @(posedge clk); #1;
                checkOutput($sformatf("toggle%0d", k), vecs[h2].seg, vecs[h2].dp, 1'b1);
            end
        join

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/segm.md
SEGM -- requirements
Module: segm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all registers.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port a, input, 1 bit: value bit 3 (MSB), asynchronous to clk.
REQ-004 The block SHALL have port b, input, 1 bit: value bit 2, asynchronous to clk.
REQ-005 The block SHALL have port c, input, 1 bit: value bit 1, asynchronous to clk.
REQ-006 The block SHALL have port d, input, 1 bit: value bit 0 (LSB), asynchronous to clk.
REQ-007 The block SHALL have ports A, B, C, D, E, F, G, each output, 1 bit, each a segment drive: A top, B upper-right, C lower-right, D bottom, E lower-left, F upper-left, G middle; 1 = lit.
REQ-008 The block SHALL have port Dp, output, 1 bit: decimal point; 1 = lit.
REQ-009 The block SHALL have port digit, output, 1 bit: digit enable; 1 = digit on.

Function
REQ-010 The block SHALL form value V = {a,b,c,d}, with a as bit 3 and d as bit 0.
REQ-011 Each of a, b, c, d SHALL pass through a two-flop synchronizer clocked by clk before decode.
REQ-012 The block SHALL decode the synchronized V to segments A..G, listed as A B C D E F G:
  0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000,
  8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-013 Dp SHALL be 1 when V > 9 (hex letter shown), and 0 when V <= 9.
REQ-014 All outputs SHALL be registered on clk, with no combinational path from any input to any output.
REQ-015 Latency SHALL be exactly 3 rising clk edges from a stable input change to the matching output: 2 synchronizer stages plus 1 output register.
REQ-016 If inputs change within one clock period, the outputs SHALL track each sampled value in order, with no filtering or debounce.
REQ-017 digit SHALL be 1 on every clock edge after reset release and SHALL never deassert while rst is low.
REQ-018 Every 4-bit V SHALL be legal; there SHALL be no undefined or default-blank decode.

Reset
REQ-019 While rst = 1, the block SHALL asynchronously force A..G, Dp and digit to 0 (display blank).
REQ-020 While rst = 1, the block SHALL asynchronously force all synchronizer flops to 0.
REQ-021 On the first clk edge after rst falls, the block SHALL drive outputs for V = 0 held in the synchronizer: A..G = 1111110, Dp = 0, digit = 1.
REQ-022 If rst asserts mid-operation, the outputs SHALL blank immediately without waiting for clk, and the pipeline contents SHALL be discarded.

Verification
REQ-023 The bench SHALL hold rst = 1 with inputs = 0000 and check that A..G, Dp and digit are all 0, including before any clk edge.
REQ-024 The bench SHALL release rst with inputs = 0000 and check A..G = 1111110, Dp = 0, digit = 1 after the first edge.
REQ-025 The bench SHALL sweep V = 0..F, holding each for 5 clocks, and check every REQ-012 pattern; Dp SHALL be 1 exactly for A..F.
REQ-026 The bench SHALL step V from 0111 to 1000 and check the outputs change from 1110000 to 1111111 on the 3rd edge, no earlier.
REQ-027 The bench SHALL toggle a, b, c, d at unrelated periods (17, 29, 39, 61 ns) against a 10 ns clk for 600 ns, and check that the outputs always match the REQ-012 decode of the input sampled 3 edges earlier.
REQ-028 The bench SHALL assert rst between clk edges during the sweep and check that the outputs blank immediately and that digit = 0.
